// File: rtl/pm_loader_pkg.sv
// Shared types and defaults for the serial program-memory boot loader.
package pm_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_DATA,
        GET_CSUM,
        DONE,
        ERROR
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] DEFAULT_START_ADDR = 8'h00;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, down-counting bit timer, LSB-first shifter.
//
// state    | meaning
// ---------+--------------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | timing to mid start bit; high there means a glitch
// RX_DATA  | sampling 8 data bits at mid-bit, LSB first
// RX_STOP  | sampling the stop bit; 1 = byte_valid, 0 = frame_err
module uart_rx_byte
    import pm_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    rx_sync;
    logic          rx_prev;
    logic          rx_s;
    rx_state_t     state;
    logic [CW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rx_s = rx_sync[1];

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    // Receive state machine; the timer reaches zero at each mid-bit sample point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= RX_START;
                        timer <= HALF_RELOAD;
                    end
                end
                RX_START: begin
                    if (timer == '0) begin
                        if (rx_s) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            timer   <= FULL_RELOAD;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (timer == '0) begin
                        shift <= {rx_s, shift[7:1]};
                        timer <= FULL_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (timer == '0) begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pm_loader.sv
// Serial boot loader: writes a framed, checksummed image into program memory
// and holds the CPU in reset until a good image has landed.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame seen since reset; waiting for SYNC_BYTE
// GET_LEN  | next byte is LEN (0 means 256 words)
// GET_DATA | each byte is written to program memory, then address advances
// GET_CSUM | next byte is compared against the running sum
// DONE     | image good, CPU released; SYNC_BYTE starts a reload
// ERROR    | checksum or framing failure; CPU held; SYNC_BYTE retries
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter logic [7:0] START_ADDR   = DEFAULT_START_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] pm_wr_addr,
    output logic [7:0] pm_wr_data,
    output logic       pm_wren,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error
);

    logic [7:0]   rx_byte;
    logic         byte_valid;
    logic         frame_err;
    frame_state_t state;
    logic [7:0]   sum;
    logic [8:0]   remaining;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Frame FSM with checksum, word counter and write-address counter; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sum        <= '0;
            remaining  <= '0;
            pm_wr_addr <= START_ADDR;
            pm_wr_data <= '0;
            pm_wren    <= 1'b0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            pm_wren <= 1'b0;
            // Address advances the cycle after each strobe, wrapping at 8 bits.
            if (pm_wren) begin
                pm_wr_addr <= pm_wr_addr + 8'd1;
            end
            case (state)
                IDLE, DONE, ERROR: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        state      <= GET_LEN;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        pm_wr_addr <= START_ADDR;
                        sum        <= '0;
                    end
                end
                GET_LEN: begin
                    if (frame_err) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (byte_valid) begin
                        remaining <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                        sum       <= sum + rx_byte;
                        state     <= GET_DATA;
                    end
                end
                GET_DATA: begin
                    if (frame_err) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (byte_valid) begin
                        pm_wr_data <= rx_byte;
                        pm_wren    <= 1'b1;
                        sum        <= sum + rx_byte;
                        remaining  <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= GET_CSUM;
                        end
                    end
                end
                GET_CSUM: begin
                    if (frame_err) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_byte == sum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: table of whole frames plus hand sequences for
// glitch rejection, framing errors and asynchronous reset.
module tb_pm_loader;
    import pm_loader_pkg::*;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] addr_a, data_a, addr_b, data_b;
    logic       wren_a, hold_a, done_a, err_a;
    logic       wren_b, hold_b, done_b, err_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] wq_a[$];
    logic [15:0] wq_b[$];

    typedef struct packed {
        logic [63:0] frame;   // byte 0 in the top bits
        logic [3:0]  nbytes;
        logic [1:0]  nwr;
        logic [23:0] wdata;   // first written word in the top bits
        logic        done;
        logic        err;
        logic        hold;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    pm_loader #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .reset(reset), .rx(rx),
        .pm_wr_addr(addr_a), .pm_wr_data(data_a), .pm_wren(wren_a),
        .cpu_hold(hold_a), .load_done(done_a), .load_error(err_a)
    );

    pm_loader #(.CLKS_PER_BIT(CPB), .START_ADDR(8'hFE)) dut_b (
        .clk(clk), .reset(reset), .rx(rx),
        .pm_wr_addr(addr_b), .pm_wr_data(data_b), .pm_wren(wren_b),
        .cpu_hold(hold_b), .load_done(done_b), .load_error(err_b)
    );

    always @(negedge clk) begin
        if (wren_a) wq_a.push_back({addr_a, data_a});
        if (wren_b) wq_b.push_back({addr_b, data_b});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] w;
        vecs[0] = '{frame: {8'hA5, 8'h03, 8'hC8, 8'hCF, 8'hD8, 8'h72, 16'h0}, nbytes: 4'd6,
                    nwr: 2'd3, wdata: 24'hC8CFD8, done: 1'b1, err: 1'b0, hold: 1'b0};
        vecs[1] = '{frame: {8'hA5, 8'h03, 8'hC8, 8'hCF, 8'hD8, 8'h73, 16'h0}, nbytes: 4'd6,
                    nwr: 2'd3, wdata: 24'hC8CFD8, done: 1'b0, err: 1'b1, hold: 1'b1};
        vecs[2] = vecs[0];
        vecs[3] = '{frame: {8'h11, 8'h22, 8'hA5, 8'h01, 8'h0F, 8'h10, 16'h0}, nbytes: 4'd6,
                    nwr: 2'd1, wdata: 24'h0F0000, done: 1'b1, err: 1'b0, hold: 1'b0};
        vecs[4] = '{frame: {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09, 16'h0}, nbytes: 4'd6,
                    nwr: 2'd3, wdata: 24'h010203, done: 1'b1, err: 1'b0, hold: 1'b0};

        // reset values
        @(negedge clk);
        chk("rst_hold", hold_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_wren", wren_a, 0);
        chk("rst_addr_a", addr_a, 8'h00);
        chk("rst_addr_b", addr_b, 8'hFE);
        chk("rst_data", data_a, 8'h00);

        // idle line
        reset = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("idle_writes", wq_a.size(), 0);
        chk("idle_hold", hold_a, 1);
        chk("idle_done", done_a, 0);

        // table of whole frames
        for (int v = 0; v < 5; v++) begin
            wq_a.delete();
            wq_b.delete();
            for (int i = 0; i < int'(vecs[v].nbytes); i++)
                send_byte(vecs[v].frame[63-8*i -: 8]);
            settle();
            chk($sformatf("v%0d_nwr_a", v), wq_a.size(), vecs[v].nwr);
            chk($sformatf("v%0d_nwr_b", v), wq_b.size(), vecs[v].nwr);
            if (wq_a.size() == int'(vecs[v].nwr) && wq_b.size() == int'(vecs[v].nwr)) begin
                for (int k = 0; k < int'(vecs[v].nwr); k++) begin
                    w = wq_a[k];
                    chk($sformatf("v%0d_addr_a%0d", v, k), w[15:8], 8'(k));
                    chk($sformatf("v%0d_data_a%0d", v, k), w[7:0], vecs[v].wdata[23-8*k -: 8]);
                    w = wq_b[k];
                    chk($sformatf("v%0d_addr_b%0d", v, k), w[15:8], 8'(8'hFE + 8'(k)));
                end
            end
            chk($sformatf("v%0d_done", v), done_a, vecs[v].done);
            chk($sformatf("v%0d_err", v), err_a, vecs[v].err);
            chk($sformatf("v%0d_hold", v), hold_a, vecs[v].hold);
            chk($sformatf("v%0d_done_b", v), done_b, vecs[v].done);
        end

        // 2-cycle glitch inside a frame must not produce a byte
        wq_a.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        @(posedge clk);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        send_byte(8'h0F);
        send_byte(8'h10);
        settle();
        chk("glitch_nwr", wq_a.size(), 1);
        if (wq_a.size() == 1) chk("glitch_word", wq_a[0], 16'h000F);
        chk("glitch_done", done_a, 1);

        // stop bit forced low on the second data byte
        wq_a.delete();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hC8);
        send_byte(8'hCF, 1'b0);
        settle();
        chk("ferr_err", err_a, 1);
        chk("ferr_hold", hold_a, 1);
        chk("ferr_done", done_a, 0);
        chk("ferr_nwr", wq_a.size(), 1);
        chk("ferr_addr", addr_a, 8'h01);

        // asynchronous reset while in ERROR
        reset = 1'b0;
        #1;
        chk("rst_err_clr", err_a, 0);
        chk("rst_err_addr", addr_a, 8'h00);
        chk("rst_err_data", data_a, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // asynchronous reset mid-frame, partway through the second data byte
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hC8);
        rx = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        chk("mid_addr_pre", addr_a, 8'h01);
        reset = 1'b0;
        rx = 1'b1;
        #1;
        chk("mid_hold", hold_a, 1);
        chk("mid_done", done_a, 0);
        chk("mid_wren", wren_a, 0);
        chk("mid_addr_a", addr_a, 8'h00);
        chk("mid_addr_b", addr_b, 8'hFE);
        chk("mid_data", data_a, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        wq_a.delete();
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("post_rst_writes", wq_a.size(), 0);
        chk("post_rst_hold", hold_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
